// File: rtl/cpu_pkg.sv
// Shared widths and fetch FSM state encoding for the CPU front-end slice.
package cpu_pkg;

  localparam int unsigned PC_W    = 4;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned CNT_W   = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

endpackage

// File: rtl/fetch_out_stage.sv
// Single-entry valid/ready register between the fetch PC and decode.
module fetch_out_stage #(
  parameter int unsigned PC_W    = cpu_pkg::PC_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               ready,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  // Flush beats load; without load the entry holds until decode takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Combinational 16-entry instruction ROM holding the default program.
module instruction_memory
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] instr
);

  localparam logic [INSTR_W-1:0] PROGRAM [16] = '{
    9'h000, 9'h015, 9'h021, 9'h0B8, 9'h0CB, 9'h1A3, 9'h0F0, 9'h155,
    9'h0AA, 9'h123, 9'h1FF, 9'h042, 9'h0C3, 9'h111, 9'h08E, 9'h1E1
  };

  assign instr = PROGRAM[addr];

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC and run-control FSM; feeds ROM data into the output stage.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W    = cpu_pkg::PC_W,
  parameter int unsigned     INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] LAST_PC = '1,
  parameter bit              WRAP    = 1'b0,
  parameter int unsigned     CNT_W   = cpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [1:0]      state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic            slot_free, issue, flush, accept, cnt_clr, done_n, busy_n;

  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready && !flush;
  assign pc_addr   = pc;

  fetch_out_stage #(
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (issue),
    .flush  (flush),
    .ready  (out_ready),
    .d_instr(instr_in),
    .d_pc   (pc),
    .valid  (out_valid),
    .instr  (out_instr),
    .pc     (out_pc)
  );

  // Next state: redirect > halt > issue; PC returns to 0 whenever IDLE is entered.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    issue   = 1'b0;
    flush   = 1'b0;
    cnt_clr = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          cnt_clr = 1'b1;
        end
      end
      S_FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_n  = redirect_pc;
        end else if (halt_req) begin
          state_n = S_DRAIN;
        end else if (slot_free) begin
          issue = 1'b1;
          if (pc == LAST_PC) begin
            if (WRAP) pc_n = '0;
            else      state_n = S_DRAIN;
          end else begin
            pc_n = pc + PC_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_n    = redirect_pc;
          state_n = S_FETCH;
        end else if (slot_free) begin
          state_n = S_IDLE;
          pc_n    = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        pc_n    = '0;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      done  <= done_n;
      busy  <= busy_n;
      if (cnt_clr)
        fetch_count <= '0;
      else if (accept && (fetch_count != '1))
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: dut0 ends at PC 4, dut1 wraps at PC 4; both checked against a stream model.
module tb_fetch_sequencer;

  localparam int LAST    = 4;
  localparam int CNT_MAX = 255;

  logic       clk;
  logic       rst_s      [2];
  logic       start_s    [2];
  logic       halt_s     [2];
  logic       redir_s    [2];
  logic [3:0] redir_pc_s [2];
  logic       ready_s    [2];
  logic [3:0] pc_addr    [2];
  logic [8:0] instr_in   [2];
  logic       out_valid  [2];
  logic [8:0] out_instr  [2];
  logic [3:0] out_pc     [2];
  logic       busy       [2];
  logic       done       [2];
  logic [7:0] fetch_count[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fetch_sequencer #(
      .PC_W(4), .INSTR_W(9), .LAST_PC(4'h4), .WRAP(g == 1), .CNT_W(8)
    ) u_dut (
      .clk(clk), .rst(rst_s[g]), .start(start_s[g]), .halt_req(halt_s[g]),
      .redirect_valid(redir_s[g]), .redirect_pc(redir_pc_s[g]),
      .pc_addr(pc_addr[g]), .instr_in(instr_in[g]),
      .out_valid(out_valid[g]), .out_ready(ready_s[g]),
      .out_instr(out_instr[g]), .out_pc(out_pc[g]),
      .busy(busy[g]), .done(done[g]), .fetch_count(fetch_count[g])
    );
    instruction_memory u_rom (.addr(pc_addr[g]), .instr(instr_in[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int pc; int instr; } xfer_t;
  xfer_t sb0[$];
  xfer_t sb1[$];

  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] rom_m [16];

  // Reference model: phase 0 idle, 1 running, 2 draining; one-deep output slot.
  int m_phase[2], m_next[2], m_spc[2], m_cnt[2];
  bit m_sv[2], m_done[2], m_rst[2];
  int e_pcaddr[2], e_cnt[2];
  bit e_valid[2], e_busy[2], e_done[2], e_rst[2];

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h at %0t", d, name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d);
    bit acc;
    xfer_t x;
    m_done[d] = 1'b0;
    m_rst[d]  = 1'b0;
    if (rst_s[d]) begin
      m_phase[d] = 0; m_next[d] = 0; m_sv[d] = 1'b0; m_cnt[d] = 0; m_rst[d] = 1'b1;
      return;
    end
    acc = m_sv[d] && ready_s[d] && !(redir_s[d] && m_phase[d] != 0);
    if (acc) begin
      x.pc = m_spc[d];
      x.instr = int'(rom_m[m_spc[d]]);
      if (d == 0) sb0.push_back(x); else sb1.push_back(x);
      if (m_cnt[d] < CNT_MAX) m_cnt[d]++;
      m_sv[d] = 1'b0;
    end
    if (m_phase[d] == 0) begin
      if (start_s[d]) begin m_phase[d] = 1; m_cnt[d] = 0; end
    end else if (redir_s[d]) begin
      m_sv[d] = 1'b0; m_next[d] = int'(redir_pc_s[d]); m_phase[d] = 1;
    end else if (m_phase[d] == 1) begin
      if (halt_s[d]) m_phase[d] = 2;
      else if (!m_sv[d]) begin
        m_sv[d] = 1'b1;
        m_spc[d] = m_next[d];
        if (m_next[d] == LAST) begin
          if (d == 1) m_next[d] = 0; else m_phase[d] = 2;
        end else m_next[d] = (m_next[d] + 1) % 16;
      end
    end else if (!m_sv[d]) begin
      m_phase[d] = 0; m_next[d] = 0; m_done[d] = 1'b1;
    end
  endtask

  // Snapshot what this cycle should show, then advance with this cycle's inputs.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      e_valid[d] = m_sv[d]; e_pcaddr[d] = m_next[d]; e_busy[d] = (m_phase[d] != 0);
      e_done[d] = m_done[d]; e_cnt[d] = m_cnt[d]; e_rst[d] = m_rst[d];
      model_step(d);
    end
  end

  // Monitor: status every cycle, transfers popped from the scoreboard on accept.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      xfer_t x;
      chk(d, "out_valid", 32'(out_valid[d]), 32'(e_valid[d]));
      chk(d, "pc_addr", 32'(pc_addr[d]), 32'(e_pcaddr[d]));
      chk(d, "busy", 32'(busy[d]), 32'(e_busy[d]));
      chk(d, "done", 32'(done[d]), 32'(e_done[d]));
      chk(d, "fetch_count", 32'(fetch_count[d]), 32'(e_cnt[d]));
      if (e_rst[d]) begin
        chk(d, "rst_out_instr", 32'(out_instr[d]), 32'd0);
        chk(d, "rst_out_pc", 32'(out_pc[d]), 32'd0);
      end
      if (out_valid[d] && ready_s[d] && !redir_s[d]) begin
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          chk(d, "unexpected_xfer", 32'(out_pc[d]), 32'hFFFF_FFFF);
        end else begin
          x = (d == 0) ? sb0.pop_front() : sb1.pop_front();
          chk(d, "xfer_pc", 32'(out_pc[d]), 32'(x.pc));
          chk(d, "xfer_instr", 32'(out_instr[d]), 32'(x.instr));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 64 && busy[d]; i++) cyc(1);
    chk(d, "idle_timeout", 32'(busy[d]), 32'd0);
  endtask

  task automatic kick(input int d);
    start_s[d] = 1'b1; cyc(1); start_s[d] = 1'b0;
  endtask

  task automatic randomize_inputs(input int d);
    rst_s[d]      = ($urandom_range(0, 199) == 0);
    start_s[d]    = ($urandom_range(0, 9) == 0);
    halt_s[d]     = ($urandom_range(0, 29) == 0);
    redir_s[d]    = ($urandom_range(0, 19) == 0);
    redir_pc_s[d] = 4'($urandom_range(0, 15));
    ready_s[d]    = ($urandom_range(0, 3) != 0);
  endtask

  task automatic quiesce(input int d);
    rst_s[d] = 1'b0; start_s[d] = 1'b0; redir_s[d] = 1'b0; ready_s[d] = 1'b1;
    halt_s[d] = 1'b1; cyc(1); halt_s[d] = 1'b0;
    wait_idle(d);
  endtask

  initial begin
    int seq[4];
    seq = '{3, 4, 0, 1};
    rom_m = '{9'h000, 9'h015, 9'h021, 9'h0B8, 9'h0CB, 9'h1A3, 9'h0F0, 9'h155,
              9'h0AA, 9'h123, 9'h1FF, 9'h042, 9'h0C3, 9'h111, 9'h08E, 9'h1E1};
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; halt_s[d] = 1'b0;
      redir_s[d] = 1'b0; redir_pc_s[d] = 4'd0; ready_s[d] = 1'b0;
    end
    cyc(2);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    chk(0, "reset_out_instr", 32'(out_instr[0]), 32'd0);

    // Full run to LAST_PC with decode always ready.
    ready_s[0] = 1'b1;
    kick(0); cyc(1);
    chk(0, "first_out_pc", 32'(out_pc[0]), 32'd0);
    wait_idle(0); cyc(2);
    chk(0, "run_count", 32'(fetch_count[0]), 32'd5);

    // Backpressure while out_pc=2.
    kick(0); cyc(3);
    ready_s[0] = 1'b0;
    chk(0, "bp_out_pc", 32'(out_pc[0]), 32'd2);
    cyc(2);
    chk(0, "bp_hold_instr", 32'(out_instr[0]), 32'h021);
    chk(0, "bp_hold_pc_addr", 32'(pc_addr[0]), 32'd3);
    ready_s[0] = 1'b1;
    wait_idle(0); cyc(2);

    // Redirect to PC 1 while out_pc=3.
    kick(0); cyc(4);
    redir_s[0] = 1'b1; redir_pc_s[0] = 4'd1;
    cyc(1); redir_s[0] = 1'b0;
    chk(0, "redir_flush", 32'(out_valid[0]), 32'd0);
    cyc(1);
    chk(0, "redir_target_pc", 32'(out_pc[0]), 32'd1);
    chk(0, "redir_target_instr", 32'(out_instr[0]), 32'h015);
    wait_idle(0); cyc(2);
    chk(0, "redir_count", 32'(fetch_count[0]), 32'd7);

    // Halt at out_pc=1 under backpressure.
    kick(0); cyc(2);
    halt_s[0] = 1'b1; ready_s[0] = 1'b0;
    cyc(1); halt_s[0] = 1'b0;
    cyc(1); ready_s[0] = 1'b1;
    cyc(1);
    chk(0, "halt_done", 32'(done[0]), 32'd1);
    chk(0, "halt_busy", 32'(busy[0]), 32'd0);
    cyc(1);
    chk(0, "halt_count", 32'(fetch_count[0]), 32'd2);

    // Mid-run reset with start and redirect alongside.
    kick(0); cyc(3);
    rst_s[0] = 1'b1; start_s[0] = 1'b1; redir_s[0] = 1'b1; redir_pc_s[0] = 4'd5;
    cyc(1);
    rst_s[0] = 1'b0; start_s[0] = 1'b0; redir_s[0] = 1'b0;
    chk(0, "mrst_valid", 32'(out_valid[0]), 32'd0);
    chk(0, "mrst_pc_addr", 32'(pc_addr[0]), 32'd0);
    cyc(2);
    chk(0, "mrst_idle", 32'(busy[0]), 32'd0);

    for (int i = 0; i < 600; i++) begin randomize_inputs(0); cyc(1); end
    quiesce(0);

    // Wrap run: out_pc 3,4,0,1 then saturation of the counter.
    ready_s[1] = 1'b1;
    kick(1); cyc(4);
    for (int i = 0; i < 4; i++) begin
      chk(1, "wrap_seq", 32'(out_pc[1]), 32'(seq[i]));
      cyc(1);
    end
    cyc(316);
    chk(1, "sat_count", 32'(fetch_count[1]), 32'd255);
    quiesce(1);

    for (int i = 0; i < 400; i++) begin randomize_inputs(1); cyc(1); end
    quiesce(1);
    cyc(2);

    chk(0, "sb_left", 32'(sb0.size()), 32'd0);
    chk(1, "sb_left", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
